hv_bundle_buffer: RTL
=====================

Name: hv_bundle_buffer

Overview:
Parametrised bundling buffer for the HPU encoder back end.
- Accumulates a stream of binary hypervector chunks into per-dimension signed saturating counters (majority bundling).
- On request, snapshots the per-dimension sign into an encoded hypervector register.
- Serves that register as addressable OUT_W-bit words to the stream port.
- Adds over the previous generation: arbitrary dimension, multi-chunk input, configurable tie-break, optional clear-on-snapshot, protocol error flag.

Parameters:
- DIM, 256, hypervector dimension; a multiple of IN_W and OUT_W.
- IN_W, 32, input chunk width (dimensions per beat).
- OUT_W, 64, stream word width.
- CNT_W, 8, signed counter width per dimension (>=2).
- TIE_ONE, 0, sign bit emitted when a counter equals 0.
- CLEAR_ON_FIN, 1, clear counters during the snapshot cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  chunk beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_data  in  IN_W  chunk bits; bit i maps to dimension chunk_ptr*IN_W+i.
- in_last  in  1  final chunk of one hypervector.
- get_fin  in  1  snapshot request pulse.
- hv_valid  out  1  encoded register holds a snapshot.
- hv_count  out  16  hypervectors bundled since last clear, saturating at 16'hFFFF.
- err  out  1  sticky protocol error.
- stream_v  in  1  stream read strobe.
- stream_a  in  8  stream word address.
- stream_d  out  OUT_W  read data.
- stream_dv  out  1  stream_d valid, one cycle after stream_v.

Behaviour:
- Clock, reset and polarity: one clock, clk; reset rst is synchronous, active-high; all state updates on posedge clk.
- Reset values: counters 0, chunk_ptr 0, state ACCUM, encoded 0, hv_valid 0, hv_count 0, err 0, stream_d 0, stream_dv 0.
- States: ACCUM, SNAP.
- in_ready = (state==ACCUM) & !get_fin. This is combinational.
- Accepted beat, per dimension: bit 1 gives +1, bit 0 gives -1.
  - Saturate to the range [-2^(CNT_W-1), 2^(CNT_W-1)-1].
  - No wrap, ever.
- chunk_ptr behaviour:
  - Increments on each accepted beat.
  - Wraps to 0 after NCHUNK-1, where NCHUNK = DIM/IN_W.
  - An accepted in_last forces chunk_ptr to 0 and increments hv_count.
  - in_last with chunk_ptr != NCHUNK-1 sets err.
  - A wrap without in_last also sets err.
- Snapshot request, ACCUM to SNAP:
  - get_fin in ACCUM with chunk_ptr==0 moves to SNAP.
  - get_fin with chunk_ptr != 0 is ignored and sets err.
  - get_fin while in SNAP is ignored; err is not set.
- SNAP, exactly one cycle:
  - encoded[d] <= (cnt[d] > 0) | (cnt[d]==0 & TIE_ONE).
  - hv_valid <= 1.
  - If CLEAR_ON_FIN: all counters <= 0 and hv_count <= 0 in the same edge.
  - Next state is ACCUM.
- Snapshot latency: get_fin at cycle t; encoded is updated at the t+1 edge and is visible from t+2.
- Stream read: stream_v at cycle t with address A gives, at the t+1 edge:
  - stream_d <= encoded[A*OUT_W +: OUT_W] if A < DIM/OUT_W, else 0.
  - stream_dv <= 1.
  - Without stream_v: stream_d holds its value and stream_dv <= 0.
- Read during the snapshot edge: a read issued in the SNAP cycle returns the pre-snapshot encoded value.
- hv_valid is cleared only by rst.
- err is cleared only by rst.
- Reset mid-accumulation discards all partial counts and the pointer.

Decomposition:
- Package hpu_buffer_pkg:
  - state enum (ACCUM, SNAP).
  - function clog2-based NCHUNK / NWORD helpers.
  - saturation limit constants derived from CNT_W.
- One sub-module, hv_sat_counter (CNT_W parameter):
  - inputs: clk, rst, en, bit_in, clr.
  - output: sign (with TIE_ONE).
  - Instantiated DIM times via generate.
  - en is driven by a chunk_ptr decode.

Test Plan:
1. Majority (DIM=128, IN_W=32, OUT_W=64, CNT_W=4): bundle all-ones, all-ones, all-zeros, then get_fin -> hv_valid=1, hv_count=0 after clear; stream_a=0 and 1 -> stream_d=64'hFFFF_FFFF_FFFF_FFFF one cycle later, stream_dv=1.
2. Tie: bundle all-ones then all-zeros, get_fin, TIE_ONE=0 -> words 0; rerun with TIE_ONE=1 -> all-ones words.
3. Saturation (CNT_W=4): 10 all-ones vectors then 8 all-zeros, get_fin -> all zeros (counter 7-8 = -1); a wrapping implementation would wrongly give all ones.
4. Protocol: in_last on the 2nd beat -> err=1, chunk_ptr=0; get_fin after 1 beat -> ignored, err stays 1, encoded unchanged.
5. Address/timing: stream_a=2 (out of range) -> stream_d=0; stream_v in the SNAP cycle -> old encoded word; in_ready=0 in the get_fin and SNAP cycles.
6. Reset: assert rst after 3 beats of a vector, then bundle one 0xA5A5A5A5-pattern vector and snapshot -> stream_d = 64'hA5A5A5A5_A5A5A5A5, err=0, hv_valid=1.

Source files
------------

// File: rtl/hpu_buffer_pkg.sv
// Shared types and sizing helpers for the hypervector bundling buffer.
package hpu_buffer_pkg;

    // Two-phase control: accumulate beats, then one cycle to snapshot signs.
    typedef enum logic {
        ACCUM = 1'b0,
        SNAP  = 1'b1
    } state_t;

    localparam int HV_COUNT_W = 16;
    localparam int STREAM_AW  = 8;

    // Number of input beats that make up one hypervector.
    function automatic int nchunk(input int dim, input int in_w);
        return dim / in_w;
    endfunction

    // Number of addressable stream words in the encoded register.
    function automatic int nword(input int dim, input int out_w);
        return dim / out_w;
    endfunction

    // Pointer width for n chunks; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Saturation limits of a two's-complement counter of width cnt_w.
    function automatic int cnt_max(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    function automatic int cnt_min(input int cnt_w);
        return -(1 << (cnt_w - 1));
    endfunction

endpackage

// File: rtl/hv_sat_counter.sv
// One signed saturating vote counter for a single hypervector dimension.
module hv_sat_counter
    import hpu_buffer_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter bit TIE_ONE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bit_in,
    input  logic clr,
    output logic sign
);

    localparam logic signed [CNT_W-1:0] SAT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic signed [CNT_W-1:0] SAT_MIN = CNT_W'(cnt_min(CNT_W));

    logic signed [CNT_W-1:0] cnt;

    // Vote +1 for a one, -1 for a zero; pin at the limits instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (bit_in) begin
                if (cnt != SAT_MAX) cnt <= cnt + CNT_W'(1);
            end else begin
                if (cnt != SAT_MIN) cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign sign = (cnt > 0) | ((cnt == 0) & TIE_ONE);

endmodule

// File: rtl/hv_bundle_buffer.sv
// Majority bundling buffer: accumulates hypervector chunks into per-dimension
// counters, snapshots their signs on request and serves them as stream words.
module hv_bundle_buffer
    import hpu_buffer_pkg::*;
#(
    parameter int DIM          = 256,
    parameter int IN_W         = 32,
    parameter int OUT_W        = 64,
    parameter int CNT_W        = 8,
    parameter bit TIE_ONE      = 1'b0,
    parameter bit CLEAR_ON_FIN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_W-1:0]             in_data,
    input  logic                        in_last,
    input  logic                        get_fin,
    output logic                        hv_valid,
    output logic [HV_COUNT_W-1:0]       hv_count,
    output logic                        err,
    input  logic                        stream_v,
    input  logic [STREAM_AW-1:0]        stream_a,
    output logic [OUT_W-1:0]            stream_d,
    output logic                        stream_dv,
    output state_t                      dbg_state,
    output logic [ptr_w(DIM/IN_W)-1:0]  dbg_chunk_ptr
);

    localparam int NCHUNK = nchunk(DIM, IN_W);
    localparam int NWORD  = nword(DIM, OUT_W);
    localparam int PTR_W  = ptr_w(NCHUNK);

    state_t             state;
    logic [PTR_W-1:0]   chunk_ptr;
    logic [DIM-1:0]     encoded;
    logic [DIM-1:0]     sign_vec;
    logic [OUT_W-1:0]   rd_word;
    logic               beat;
    logic               last_chunk;
    logic               clr_cnt;

    // Handshake: a beat transfers on a cycle where in_valid and in_ready are both
    // high; in_ready drops in SNAP and whenever get_fin is asserted so that a
    // snapshot request never races an accumulating beat.
    assign in_ready   = (state == ACCUM) && !get_fin;
    assign beat       = in_valid && in_ready;
    assign last_chunk = (chunk_ptr == PTR_W'(NCHUNK - 1));
    assign clr_cnt    = (state == SNAP) && CLEAR_ON_FIN;

    assign dbg_state     = state;
    assign dbg_chunk_ptr = chunk_ptr;

    for (genvar d = 0; d < DIM; d++) begin : g_dim
        hv_sat_counter #(
            .CNT_W   (CNT_W),
            .TIE_ONE (TIE_ONE)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .en     (beat && (chunk_ptr == PTR_W'(d / IN_W))),
            .bit_in (in_data[d % IN_W]),
            .clr    (clr_cnt),
            .sign   (sign_vec[d])
        );
    end

    // Control FSM: chunk pointer, bundle count, protocol errors and snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            chunk_ptr <= '0;
            hv_count  <= '0;
            err       <= 1'b0;
            hv_valid  <= 1'b0;
            encoded   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (get_fin) begin
                        if (chunk_ptr == '0) state <= SNAP;
                        else                 err   <= 1'b1;
                    end else if (beat) begin
                        if (in_last) begin
                            chunk_ptr <= '0;
                            if (hv_count != 16'hFFFF) hv_count <= hv_count + 16'd1;
                            if (!last_chunk) err <= 1'b1;
                        end else if (last_chunk) begin
                            chunk_ptr <= '0;
                            err       <= 1'b1;
                        end else begin
                            chunk_ptr <= chunk_ptr + PTR_W'(1);
                        end
                    end
                end
                SNAP: begin
                    encoded  <= sign_vec;
                    hv_valid <= 1'b1;
                    if (CLEAR_ON_FIN) hv_count <= '0;
                    state    <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // Select the addressed word; out-of-range addresses read as zero.
    always_comb begin
        rd_word = '0;
        for (int w = 0; w < NWORD; w++) begin
            if (int'(stream_a) == w) rd_word = encoded[w*OUT_W +: OUT_W];
        end
    end

    // Registered read port: data one cycle after the strobe, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            stream_d  <= '0;
            stream_dv <= 1'b0;
        end else begin
            stream_dv <= stream_v;
            if (stream_v) stream_d <= rd_word;
        end
    end

endmodule
